// File: rtl/tc_clk_int_div.sv
// tc_clk_int_div: integer clock divider with a glitch-free output gate,
// runtime divisor reprogramming over valid/ready, and a DFT bypass.
// The divided path is a registered toggle (t_r), so it cannot glitch.
// The bypass path is clk_i through a latch-based clock gate.
// A 2:1 clock mux picks a path, and it only switches while both paths are gated low.
module tc_clk_int_div #(
   parameter int unsigned DivWidth         = 4,
   parameter int unsigned DefaultDiv       = 1,
   parameter bit          EnableTestBypass = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic                test_mode_en_i,
   input  logic [DivWidth-1:0] div_i,
   input  logic                div_valid_i,
   output logic                div_ready_o,
   output logic                clk_o,
   output logic [DivWidth-1:0] cycl_count_o
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STOP   = 2'd1,
      ST_SWITCH = 2'd2,
      ST_WAIT   = 2'd3
   } state_e;

   localparam logic [DivWidth-1:0] DivOne  = DivWidth'(1'b1);
   localparam logic [DivWidth-1:0] DivInit = DivWidth'(DefaultDiv);
   localparam logic                InitSel = (DivInit > DivOne);

   // A divisor selects divided mode when it is 2 or more; 0 and 1 mean bypass.
   function automatic logic is_divided(input logic [DivWidth-1:0] d);
      return (d > DivOne);
   endfunction

   function automatic logic [DivWidth-1:0] eff_div(input logic [DivWidth-1:0] d);
      return (d == '0) ? DivOne : d;
   endfunction

   // The high phase covers counts 0..ceil(d/2)-1.
   function automatic logic in_high_phase(input logic [DivWidth-1:0] cnt,
                                          input logic [DivWidth-1:0] d);
      logic [DivWidth:0] half;
      half = ({1'b0, d} + {{DivWidth{1'b0}}, 1'b1}) >> 1'b1;
      return ({1'b0, cnt} < half);
   endfunction

   state_e              state_r, state_s;
   logic [DivWidth-1:0] div_r, div_s;
   logic [DivWidth-1:0] cnt_r, cnt_s;
   logic [DivWidth-1:0] pend_div_r, pend_div_s;
   logic                t_r, t_s;
   logic                gate_en_r, gate_en_s;
   logic                sel_r, sel_s;
   logic                pend_r, pend_s;
   logic                en_lat_r;
   logic [DivWidth-1:0] deff_s;
   logic [DivWidth-1:0] cnt_inc_s;
   logic                div_mode_s;
   logic                boundary_s;
   logic                same_mode_s;
   logic                byp_clk_s;
   logic                mux_clk_s;

   assign deff_s      = eff_div(div_r);
   assign div_mode_s  = is_divided(div_r);
   assign cnt_inc_s   = cnt_r + DivOne;
   // A disabled output or bypass mode makes every cycle a period boundary.
   assign boundary_s  = !gate_en_r || !div_mode_s || (cnt_r == (deff_s - DivOne));
   assign same_mode_s = (is_divided(pend_div_r) == div_mode_s);

   // Next-state logic: counter, toggle, enable sampling, request capture and divisor apply.
   always_comb begin
      state_s    = state_r;
      div_s      = div_r;
      cnt_s      = cnt_r;
      t_s        = 1'b0;
      gate_en_s  = gate_en_r;
      sel_s      = sel_r;
      pend_s     = pend_r;
      pend_div_s = pend_div_r;

      if (div_valid_i && !pend_r) begin
         pend_s     = 1'b1;
         pend_div_s = div_i;
      end else begin
         pend_div_s = pend_div_r;
      end

      case (state_r)
         ST_RUN: begin
            if (boundary_s && pend_r && same_mode_s) begin
               div_s     = pend_div_r;
               cnt_s     = '0;
               pend_s    = 1'b0;
               gate_en_s = en_i;
               t_s       = en_i & is_divided(pend_div_r);
            end else if (boundary_s && pend_r) begin
               state_s   = ST_STOP;
               cnt_s     = '0;
               gate_en_s = 1'b0;
            end else if (boundary_s) begin
               cnt_s     = '0;
               gate_en_s = en_i;
               t_s       = en_i & div_mode_s;
            end else begin
               cnt_s = cnt_inc_s;
               t_s   = in_high_phase(cnt_inc_s, div_r);
            end
         end
         ST_STOP: begin
            state_s   = ST_SWITCH;
            cnt_s     = '0;
            gate_en_s = 1'b0;
         end
         ST_SWITCH: begin
            // Both paths are gated low here, so the mux can change path safely.
            state_s   = ST_WAIT;
            div_s     = pend_div_r;
            cnt_s     = '0;
            pend_s    = 1'b0;
            gate_en_s = 1'b0;
            sel_s     = is_divided(pend_div_r);
         end
         ST_WAIT: begin
            state_s   = ST_RUN;
            cnt_s     = '0;
            gate_en_s = en_i;
            t_s       = en_i & div_mode_s;
         end
         default: begin
            state_s   = ST_RUN;
            cnt_s     = '0;
            gate_en_s = 1'b0;
         end
      endcase
   end

   // State registers, with an asynchronous return to the reset configuration.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= ST_RUN;
         div_r      <= DivInit;
         cnt_r      <= '0;
         t_r        <= 1'b0;
         gate_en_r  <= 1'b0;
         sel_r      <= InitSel;
         pend_r     <= 1'b0;
         pend_div_r <= '0;
      end else begin
         state_r    <= state_s;
         div_r      <= div_s;
         cnt_r      <= cnt_s;
         t_r        <= t_s;
         gate_en_r  <= gate_en_s;
         sel_r      <= sel_s;
         pend_r     <= pend_s;
         pend_div_r <= pend_div_s;
      end
   end

   // Bypass-path clock gate: the enable only moves while clk_i is low.
   always_latch begin
      if (!rst_ni) begin
         en_lat_r = 1'b0;
      end else if (!clk_i) begin
         en_lat_r = gate_en_r;
      end
   end

   assign byp_clk_s    = clk_i & en_lat_r;
   assign mux_clk_s    = sel_r ? t_r : byp_clk_s;
   assign clk_o        = (EnableTestBypass && test_mode_en_i) ? clk_i : mux_clk_s;
   assign div_ready_o  = ~pend_r;
   assign cycl_count_o = cnt_r;

endmodule

// File: tb/tb_tc_clk_int_div.sv
// Directed bench for tc_clk_int_div (DivWidth=4, DefaultDiv=1, test bypass on).
// Each cycle samples clk_o in the high phase (posedge+1) and the low phase (negedge+1).
module tb_tc_clk_int_div;

   logic       clk_i;
   logic       rst_ni;
   logic       en_i;
   logic       test_mode_en_i;
   logic [3:0] div_i;
   logic       div_valid_i;
   logic       div_ready_o;
   logic       clk_o;
   logic [3:0] cycl_count_o;

   int n_tests = 0;
   int n_fail  = 0;

   tc_clk_int_div #(
      .DivWidth         (4),
      .DefaultDiv       (1),
      .EnableTestBypass (1'b1)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .en_i           (en_i),
      .test_mode_en_i (test_mode_en_i),
      .div_i          (div_i),
      .div_valid_i    (div_valid_i),
      .div_ready_o    (div_ready_o),
      .clk_o          (clk_o),
      .cycl_count_o   (cycl_count_o)
   );

   initial clk_i = 1'b0;
   // 10 ns source clock
   always #5 clk_i = ~clk_i;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_tests++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
      end
   endtask

   task automatic run_cycle(input string tag, input int exp_cnt, input int exp_hi, input int exp_lo);
      @(posedge clk_i);
      #1;
      check_value({tag, ".cnt"}, 32'(cycl_count_o), 32'(exp_cnt));
      check_value({tag, ".hi"}, 32'(clk_o), 32'(exp_hi));
      @(negedge clk_i);
      #1;
      check_value({tag, ".lo"}, 32'(clk_o), 32'(exp_lo));
   endtask

   task automatic run_div(input string tag, input int exp_cnt, input int exp_clk);
      run_cycle(tag, exp_cnt, exp_clk, exp_clk);
   endtask

   task automatic check_ready(input string tag, input int exp_rdy);
      check_value(tag, 32'(div_ready_o), 32'(exp_rdy));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ni         = 1'b0;
      en_i           = 1'b1;
      test_mode_en_i = 1'b0;
      div_i          = 4'd0;
      div_valid_i    = 1'b0;

      // reset: output held low, ready high
      run_cycle("rst0", 0, 0, 0);
      run_cycle("rst1", 0, 0, 0);
      check_ready("rst_rdy", 1);
      rst_ni = 1'b1;

      // bypass after release: clk_o follows clk_i from the second edge
      run_cycle("byp1", 0, 0, 0);
      run_cycle("byp2", 0, 1, 0);
      run_cycle("byp3", 0, 1, 0);
      check_ready("byp_rdy", 1);

      // bypass -> divide by 4 through STOP/SWITCH/WAIT
      div_i = 4'd4; div_valid_i = 1'b1;
      run_cycle("d4_acc", 0, 1, 0);  check_ready("d4_rdy0", 0); div_valid_i = 1'b0;
      run_cycle("d4_stop", 0, 1, 0); check_ready("d4_rdy1", 0);
      run_cycle("d4_sw", 0, 0, 0);   check_ready("d4_rdy2", 0);
      run_cycle("d4_wait", 0, 0, 0); check_ready("d4_rdy3", 1);
      run_div("d4_c0", 0, 1);
      run_div("d4_c1", 1, 1);
      run_div("d4_c2", 2, 0);
      run_div("d4_c3", 3, 0);
      run_div("d4_c0b", 0, 1);
      run_div("d4_c1b", 1, 1);

      // 4 -> 5 requested at cnt 1: period ends at cnt 3, then 3 high + 2 low
      div_i = 4'd5; div_valid_i = 1'b1;
      run_div("d5_acc", 2, 0); check_ready("d5_rdy0", 0); div_valid_i = 1'b0;
      run_div("d5_c3", 3, 0);
      run_div("d5_c0", 0, 1);  check_ready("d5_rdy1", 1);
      run_div("d5_c1", 1, 1);
      run_div("d5_c2", 2, 1);
      run_div("d5_c3b", 3, 0);
      run_div("d5_c4", 4, 0);
      run_div("d5_c0b", 0, 1);

      // program 6, drop en_i at cnt 0, then reassert
      div_i = 4'd6; div_valid_i = 1'b1;
      run_div("d6_acc", 1, 1); check_ready("d6_rdy0", 0); div_valid_i = 1'b0;
      run_div("d6_c2", 2, 1);
      run_div("d6_c3", 3, 0);
      run_div("d6_c4", 4, 0);
      run_div("d6_c0", 0, 1);  check_ready("d6_rdy1", 1); en_i = 1'b0;
      run_div("en_c1", 1, 1);
      run_div("en_c2", 2, 1);
      run_div("en_c3", 3, 0);
      run_div("en_c4", 4, 0);
      run_div("en_c5", 5, 0);
      run_div("off0", 0, 0);
      run_div("off1", 0, 0);
      run_div("off2", 0, 0);
      en_i = 1'b1;
      run_div("on0", 0, 1);
      run_div("on1", 1, 1);
      run_div("on2", 2, 1);
      run_div("on3", 3, 0);

      // back-to-back requests 3 then 7 with valid held high
      div_i = 4'd3; div_valid_i = 1'b1;
      run_div("b2b_acc3", 4, 0); check_ready("b2b_rdy0", 0); div_i = 4'd7;
      run_div("b2b_hold", 5, 0); check_ready("b2b_rdy1", 0);
      run_div("b2b_app3", 0, 1); check_ready("b2b_rdy2", 1);
      run_div("b2b_acc7", 1, 1); check_ready("b2b_rdy3", 0); div_valid_i = 1'b0;
      run_div("b2b_d3c2", 2, 0); check_ready("b2b_rdy4", 0);
      run_div("b2b_app7", 0, 1); check_ready("b2b_rdy5", 1);
      run_div("d7_c1", 1, 1);
      run_div("d7_c2", 2, 1);
      run_div("d7_c3", 3, 1);
      run_div("d7_c4", 4, 0);
      run_div("d7_c5", 5, 0);
      run_div("d7_c6", 6, 0);
      run_div("d7_c0", 0, 1);
      run_div("d7_c1b", 1, 1);

      // test bypass during divide by 7: clk_o = clk_i, counter keeps going
      test_mode_en_i = 1'b1;
      #1;
      check_value("tm_now", 32'(clk_o), 32'd0);
      run_cycle("tm_c2", 2, 1, 0);
      run_cycle("tm_c3", 3, 1, 0);
      run_cycle("tm_c4", 4, 1, 0);
      run_cycle("tm_c5", 5, 1, 0);
      test_mode_en_i = 1'b0;
      #1;
      check_value("tm_off", 32'(clk_o), 32'd0);
      run_div("tm_c6", 6, 0);
      run_div("tm_c0", 0, 1);

      // request bypass (mode change) and reset while in STOP
      div_i = 4'd1; div_valid_i = 1'b1;
      run_div("r_acc", 1, 1); check_ready("r_rdy0", 0); div_valid_i = 1'b0;
      run_div("r_c2", 2, 1);
      run_div("r_c3", 3, 1);
      run_div("r_c4", 4, 0);
      run_div("r_c5", 5, 0);
      run_div("r_c6", 6, 0);
      run_cycle("r_stop", 0, 0, 0); check_ready("r_rdy1", 0);
      rst_ni = 1'b0;
      #1;
      check_ready("r_rst_rdy", 1);
      check_value("r_rst_cnt", 32'(cycl_count_o), 32'd0);
      check_value("r_rst_clk", 32'(clk_o), 32'd0);
      run_cycle("r_in", 0, 0, 0);
      rst_ni = 1'b1;
      run_cycle("r_rel1", 0, 0, 0);
      run_cycle("r_rel2", 0, 1, 0);
      run_cycle("r_rel3", 0, 1, 0);
      check_ready("r_rel_rdy", 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
